// File: rtl/quad_coeff_builder.sv
// Rebuilds monic coefficients b = -(r1+r2), c = r1*r2 from a real or conjugate root pair.
// Optional macro COEFF_SAT_EN: saturate b/c to W bits and flag ovf; otherwise wrap.
module quad_coeff_builder #(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_cplx,
  input  logic signed [W-1:0] x1r,
  input  logic signed [W-1:0] x2r,
  input  logic signed [W-1:0] x1i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] b,
  output logic signed [W-1:0] c,
  output logic                ovf
);

  localparam int unsigned BW   = W + 2;
  localparam int unsigned AW   = 2 * W + 1;
  localparam int unsigned CNTW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, FIN, DONE} state_t;

  state_t                state_q, state_n;
  logic                  cplx_q, cplx_n;
  logic                  neg_q, neg_n;
  logic [2*W-1:0]        mcand_q, mcand_n;
  logic [W-1:0]          mplier_q, mplier_n;
  logic [W-1:0]          sq_q, sq_n;
  logic signed [AW-1:0]  acc_q, acc_n;
  logic [CNTW-1:0]       cnt_q, cnt_n;
  logic signed [BW-1:0]  bsum_q, bsum_n;
  logic signed [W-1:0]   b_n, c_n;
  logic                  ovf_n, in_ready_n, out_valid_n;

  logic signed [BW-1:0]  x1e, x2e;
  logic signed [AW-1:0]  bext, cext;

  // Magnitude of a signed operand; -2^(W-1) maps exactly to 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  assign x1e  = $signed({{2{x1r[W-1]}}, x1r});
  assign x2e  = $signed({{2{x2r[W-1]}}, x2r});
  assign bext = $signed({{(AW-BW){bsum_q[BW-1]}}, bsum_q});
  assign cext = neg_q ? -acc_q : acc_q;

`ifdef COEFF_SAT_EN
  // Returns {clipped, value} after clamping to the W-bit signed range.
  function automatic logic [W:0] narrow(input logic [AW-1:0] v);
    logic fits;
    fits = (&v[AW-1:W-1]) | ~(|v[AW-1:W-1]);
    if (fits) return {1'b0, v[W-1:0]};
    return v[AW-1] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction
`else
  logic unused_hi;
  assign unused_hi = ^{bext[AW-1:W], cext[AW-1:W]};
`endif

  // Next-state, datapath and output logic.
  always_comb begin
    state_n     = state_q;
    cplx_n      = cplx_q;
    neg_n       = neg_q;
    mcand_n     = mcand_q;
    mplier_n    = mplier_q;
    sq_n        = sq_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    bsum_n      = bsum_q;
    b_n         = b;
    c_n         = c;
    ovf_n       = ovf;
    out_valid_n = out_valid;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_n  = MUL1;
          cplx_n   = is_cplx;
          neg_n    = is_cplx ? 1'b0 : (x1r[W-1] ^ x2r[W-1]);
          mcand_n  = {{W{1'b0}}, mag(x1r)};
          mplier_n = is_cplx ? mag(x1r) : mag(x2r);
          sq_n     = mag(x1i);
          acc_n    = '0;
          cnt_n    = '0;
          bsum_n   = is_cplx ? -(x1e + x1e) : -(x1e + x2e);
        end
      end
      MUL1, MUL2: begin
        if (mplier_q[0]) acc_n = acc_q + $signed({1'b0, mcand_q});
        mcand_n  = mcand_q << 1;
        mplier_n = mplier_q >> 1;
        cnt_n    = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(W - 1)) begin
          cnt_n = '0;
          if (state_q == MUL1 && cplx_q) begin
            state_n  = MUL2;
            mcand_n  = {{W{1'b0}}, sq_q};
            mplier_n = sq_q;
          end else begin
            state_n = FIN;
          end
        end
      end
      FIN: begin
`ifdef COEFF_SAT_EN
        b_n   = narrow(bext)[W-1:0];
        c_n   = narrow(cext)[W-1:0];
        ovf_n = narrow(bext)[W] | narrow(cext)[W];
`else
        b_n   = bext[W-1:0];
        c_n   = cext[W-1:0];
        ovf_n = 1'b0;
`endif
        out_valid_n = 1'b1;
        state_n     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          ovf_n       = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cplx_q    <= 1'b0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sq_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bsum_q    <= '0;
      b         <= '0;
      c         <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      cplx_q    <= cplx_n;
      neg_q     <= neg_n;
      mcand_q   <= mcand_n;
      mplier_q  <= mplier_n;
      sq_q      <= sq_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      bsum_q    <= bsum_n;
      b         <= b_n;
      c         <= c_n;
      ovf       <= ovf_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_quad_coeff_builder.sv
// Scoreboard bench for quad_coeff_builder; honours COEFF_SAT_EN in its reference model.
module tb_quad_coeff_builder;

  localparam int unsigned W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                is_cplx;
  logic signed [W-1:0] x1r, x2r, x1i;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] b, c;
  logic                ovf;

  quad_coeff_builder #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .is_cplx(is_cplx),
    .x1r(x1r), .x2r(x2r), .x1i(x1i),
    .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic                ovf;
    int                  e0;
    int                  lat;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic signed [W-1:0] nar(input int v, inout bit clip);
    int hi, lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
`ifdef COEFF_SAT_EN
    if (v > hi) begin clip = 1'b1; return W'(hi); end
    if (v < lo) begin clip = 1'b1; return W'(lo); end
`endif
    return W'(v);
  endfunction

  function automatic exp_t model(input bit cx, input int a1, input int a2, input int ai);
    exp_t e;
    bit   clip;
    int   bf, cf;
    clip  = 1'b0;
    bf    = cx ? -2 * a1 : -(a1 + a2);
    cf    = cx ? a1 * a1 + ai * ai : a1 * a2;
    e.b   = nar(bf, clip);
    e.c   = nar(cf, clip);
    e.ovf = clip;
    e.lat = cx ? 2 * W + 1 : W + 1;
    e.e0  = 0;
    return e;
  endfunction

  // Compare each result when out_valid rises, then demand it holds until handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_in_done", 32'(in_ready), 0);
        if (!prev_ov) begin
          if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            cur = q.pop_front();
            check("latency", cyc - cur.e0, cur.lat);
            check("b", 32'(b), 32'(cur.b));
            check("c", 32'(c), 32'(cur.c));
            check("ovf", 32'(ovf), 32'(cur.ovf));
          end
        end else begin
          check("b_hold", 32'(b), 32'(cur.b));
          check("c_hold", 32'(c), 32'(cur.c));
          check("ovf_hold", 32'(ovf), 32'(cur.ovf));
        end
      end
      prev_ov = out_valid;
    end
  end

  // Entered and left at posedge+#1; pushes the expectation when acceptance is seen.
  task automatic send(input bit cx, input logic signed [W-1:0] a1,
                      input logic signed [W-1:0] a2, input logic signed [W-1:0] ai);
    exp_t e;
    bit   acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    is_cplx  = cx;
    x1r      = a1;
    x2r      = a2;
    x1i      = ai;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e    = model(cx, int'(a1), int'(a2), int'(ai));
        e.e0 = cyc + 1;
        q.push_back(e);
        acc  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (q.size() == 0 && !out_valid && in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    logic signed [W-1:0] r1, r2, r3;
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    is_cplx   = 1'b0;
    x1r       = '0;
    x2r       = '0;
    x1i       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_b", 32'(b), 0);
    check("rst_c", 32'(c), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(1'b0, 8'sd2, 8'sd3, 8'sd0);
    wait_idle();
    send(1'b1, -8'sd1, 8'sd99, 8'sd2);
    wait_idle();
    send(1'b0, 8'sd20, 8'sd10, 8'sd0);
    send(1'b0, -8'sd100, -8'sd100, 8'sd0);
    send(1'b0, -8'sd128, 8'sd1, 8'sd0);
    send(1'b1, -8'sd128, 8'sd0, -8'sd128);
    send(1'b0, 8'sd0, -8'sd7, 8'sd5);
    for (int i = 0; i < 10; i++) begin
      r1 = W'($urandom);
      r2 = W'($urandom);
      r3 = W'($urandom);
      send(1'($urandom_range(1, 0)), r1, r2, r3);
    end
    wait_idle();

    // Backpressure: hold DONE for 5 cycles, with an in_valid pulse that must be ignored.
    out_ready = 1'b0;
    send(1'b0, 8'sd5, -8'sd7, 8'sd0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) check("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      x1r      = 8'sd1;
      x2r      = 8'sd1;
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    repeat (25) @(posedge clk);
    #1;

    // Abort in the middle of MUL1.
    send(1'b0, 8'sd2, 8'sd3, 8'sd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_b", 32'(b), 0);
    check("abort_c", 32'(c), 0);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    send(1'b0, 8'sd2, 8'sd3, 8'sd0);
    wait_idle();

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_coeff_builder.md
Name: quad_coeff_builder

Overview:
- Inverse of the quadratic root solver: takes a root pair of x^2 + b*x + c = 0 and rebuilds the monic coefficients b and c.
- Root pair is either two real roots or a complex-conjugate pair xr ± j*xi.
- Multi-cycle: one sequential shift-add multiplier, valid/ready handshakes on both sides.
- Used as a round-trip checker behind the solver and as a stimulus generator for it.

Parameters:
- W, 8, width of root inputs and coefficient outputs (signed two's complement).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  root pair presented
- in_ready  output  1  block can accept a root pair
- is_cplx  input  1  0: real roots x1r, x2r; 1: conjugate pair x1r ± j*x1i
- x1r  input  W  signed; real root 1, or real part of the conjugate pair
- x2r  input  W  signed; real root 2; ignored when is_cplx=1
- x1i  input  W  signed; imaginary magnitude; ignored when is_cplx=0
- out_valid  output  1  coefficients valid
- out_ready  input  1  consumer accepts coefficients
- b  output  W  signed; -(sum of roots)
- c  output  W  signed; product of roots
- ovf  output  1  b or c exceeded the W-bit signed range (see Optional Feature)

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, b=0, c=0, ovf=0.
  - Internal accumulator and counter are cleared.
- Reset mid-operation aborts the transaction. No out_valid is produced for it.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid && in_ready, register all inputs and go to MUL1. This edge is E0.
  - MUL1: multiply operand pair A for exactly W cycles, 8 at default.
    - Real: A = x1r*x2r.
    - Complex: A = x1r*x1r.
  - MUL2 (complex only): W cycles computing x1i*x1i, added to the MUL1 result.
  - DONE:
    - out_valid=1, b and c stable.
    - On out_valid && out_ready, go to IDLE. in_ready returns to 1 on the next cycle.
  - in_ready=0 in every state except IDLE. Inputs are not sampled outside IDLE.
- Latency:
  - out_valid rises W+1 cycles after E0 for real input (9 at default).
  - out_valid rises 2W+1 cycles after E0 for complex input (17 at default).
  - out_ready is not examined before DONE.
- Backpressure: out_valid, b and c hold unchanged while out_ready=0 in DONE, for any number of cycles.
- Multiplier:
  - Operates on magnitudes (W-bit unsigned; |−2^(W−1)| = 2^(W−1) must be exact).
  - One partial-product add/shift per cycle, LSB first.
  - Sign applied at the end: negate if operand signs differ.
  - Product accumulator is 2W+1 bits signed.
- Sum for b:
  - Computed at E0 with W+2-bit signed arithmetic.
  - Real: -(x1r + x2r). Complex: -(2*x1r).
- Narrowing: both the full-width b sum and the c accumulator reduce to W bits in DONE, per the Optional Feature.
- Back-to-back transactions: minimum 1 idle cycle between DONE handshake and the next accept (IDLE lasts ≥1 cycle).

Optional Feature:
- Macro: COEFF_SAT_EN.
- Defined:
  - b and c saturate to [-2^(W-1), 2^(W-1)-1].
  - ovf=1 in DONE when either value was clipped.
  - ovf is cleared on leaving DONE.
- Undefined:
  - b and c are the low W bits (two's-complement wrap).
  - ovf is tied to 0.
- Latency is identical in both builds.

Test Plan:
- Real roots: x1r=2, x2r=3, is_cplx=0, out_ready=1 -> out_valid 9 cycles after accept, b=-5, c=6, ovf=0.
- Complex pair: x1r=-1, x1i=2, is_cplx=1 -> out_valid 17 cycles after accept, b=2, c=5. x2r=99 must not affect the result.
- Overflow: x1r=20, x2r=10 -> with COEFF_SAT_EN: b=-30, c=127, ovf=1. Without: c=-56, ovf=0. Also x1r=x2r=-100 -> b=127, ovf=1 (SAT) / b=-56 (wrap).
- Extreme operand: x1r=-128, x2r=1 -> c=-128, b=127, ovf=0 (SAT). Checks magnitude handling of -2^(W-1).
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, b, c constant. in_ready stays 0, and an in_valid pulse during this window is ignored. Release -> in_ready=1 the cycle after the handshake.
- Reset mid-op: assert rst at cycle 4 of MUL1 -> next cycle in_ready=1, out_valid=0, b=c=0. A new transaction with x1r=2, x2r=3 then completes normally with b=-5, c=6.
